// File: rtl/dm_arbiter.sv
// Round-robin sequencer sharing the data memory between the CPU load/store port (m0) and a DMA/debug port (m1).
// Define DM_ATOMIC_EN to add the load-linked/store-conditional reservation register.
module dm_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          m0_req,
  input  logic          m1_req,
  input  logic          m0_we,
  input  logic          m1_we,
  input  logic [1:0]    m0_size,
  input  logic [1:0]    m1_size,
  input  logic          m0_ll,
  input  logic          m0_sc,
  input  logic [AW-1:0] m0_addr,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m0_wdata,
  input  logic [DW-1:0] m1_wdata,
  output logic          m0_gnt,
  output logic          m1_gnt,
  output logic          m0_rvalid,
  output logic          m1_rvalid,
  output logic [DW-1:0] m0_rdata,
  output logic [DW-1:0] m1_rdata,
  output logic          m0_scok,
  output logic [AW-1:0] Ad,
  output logic [DW-1:0] WrData,
  output logic [2:0]    MemWr,
  output logic [1:0]    DMcut_sel,
  input  logic [DW-1:0] DM
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  state_e        state_q, state_d;
  logic          lastM1_q, lastM1_d;
  logic          owner_q, owner_d;
  logic          we_q, we_d;
  logic          sc_q, sc_d;
  logic          ll_q, ll_d;
  logic [2:0]    wrCode_q, wrCode_d;
  logic [1:0]    cut_q, cut_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [1:0]    size_d;
  logic [2:0]    scCode;
  logic          scOk;
  logic          anyGnt;

  assign anyGnt = m0_gnt | m1_gnt;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (anyGnt) state_d = ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // SC always behaves as a word store; LL only counts on a plain m0 load.
  always_comb begin
    owner_d = m1_gnt;
    if (m1_gnt) begin
      we_d    = m1_we;
      sc_d    = 1'b0;
      ll_d    = 1'b0;
      size_d  = m1_size;
      addr_d  = m1_addr;
      wdata_d = m1_wdata;
    end else begin
      we_d    = m0_we | m0_sc;
      sc_d    = m0_sc;
      ll_d    = m0_ll & ~m0_we & ~m0_sc;
      size_d  = m0_sc ? 2'd0 : m0_size;
      addr_d  = m0_addr;
      wdata_d = m0_wdata;
    end
    case (size_d)
      2'd1:    begin wrCode_d = 3'd2; cut_d = 2'd1; end
      2'd2:    begin wrCode_d = 3'd4; cut_d = 2'd2; end
      default: begin wrCode_d = 3'd1; cut_d = 2'd0; end
    endcase
    lastM1_d = (state_q == RESP) ? owner_q : lastM1_q;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      owner_q  <= 1'b0;
      we_q     <= 1'b0;
      sc_q     <= 1'b0;
      ll_q     <= 1'b0;
      wrCode_q <= 3'd0;
      cut_q    <= 2'd0;
      addr_q   <= '0;
      wdata_q  <= '0;
      lastM1_q <= 1'b1;
    end else begin
      if (anyGnt) begin
        owner_q  <= owner_d;
        we_q     <= we_d;
        sc_q     <= sc_d;
        ll_q     <= ll_d;
        wrCode_q <= wrCode_d;
        cut_q    <= cut_d;
        addr_q   <= addr_d;
        wdata_q  <= wdata_d;
      end
      lastM1_q <= lastM1_d;
    end
  end

  // Grants are suppressed while Reset is held so no request is acknowledged and then dropped.
  always_comb begin
    m0_gnt    = 1'b0;
    m1_gnt    = 1'b0;
    MemWr     = 3'd0;
    m0_rvalid = 1'b0;
    m1_rvalid = 1'b0;
    m0_rdata  = '0;
    m1_rdata  = '0;
    m0_scok   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!Reset) begin
          if (m0_req && m1_req) begin
            m0_gnt = lastM1_q;
            m1_gnt = !lastM1_q;
          end else begin
            m0_gnt = m0_req;
            m1_gnt = m1_req;
          end
        end
      end
      ACCESS: begin
        if (we_q) MemWr = sc_q ? scCode : wrCode_q;
      end
      RESP: begin
        m0_rvalid = !owner_q;
        m1_rvalid = owner_q;
        if (!we_q) begin
          if (owner_q) m1_rdata = DM;
          else         m0_rdata = DM;
        end
        m0_scok = !owner_q && sc_q && scOk;
      end
      default: ;
    endcase
  end

  assign Ad        = addr_q;
  assign WrData    = wdata_q;
  assign DMcut_sel = cut_q;

`ifdef DM_ATOMIC_EN
  logic          resValid_q;
  logic [AW-3:0] resWord_q;
  logic          scPass_q;
  logic          resHit;

  assign resHit = resValid_q && (resWord_q == addr_q[AW-1:2]);
  assign scCode = resHit ? 3'd3 : 3'd0;
  assign scOk   = scPass_q;

  // Any store hitting the reserved word, including a successful SC, consumes the reservation.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      resValid_q <= 1'b0;
      resWord_q  <= '0;
      scPass_q   <= 1'b0;
    end else if (state_q == ACCESS) begin
      scPass_q <= resHit;
      if (ll_q) begin
        resValid_q <= 1'b1;
        resWord_q  <= addr_q[AW-1:2];
      end else if (we_q && resHit) begin
        resValid_q <= 1'b0;
      end
    end
  end
`else
  logic unusedLl;
  assign unusedLl = ll_q;
  assign scCode   = 3'd1;
  assign scOk     = 1'b1;
`endif

endmodule

// File: tb/tb_dm_arbiter.sv
// Self-checking bench for dm_arbiter: transaction-level reference model plus directed and random traffic.
// Honours DM_ATOMIC_EN the same way as the design.
module tb_dm_arbiter;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        m0Req = 1'b0, m1Req = 1'b0, m0We = 1'b0, m1We = 1'b0, m0Ll = 1'b0, m0Sc = 1'b0;
  logic [1:0]  m0Size = 2'd0, m1Size = 2'd0;
  logic [31:0] m0Addr = '0, m1Addr = '0, m0Wdata = '0, m1Wdata = '0, DM = '0;
  logic        m0Gnt, m1Gnt, m0Rvalid, m1Rvalid, m0Scok;
  logic [31:0] m0Rdata, m1Rdata, Ad, WrData;
  logic [2:0]  MemWr;
  logic [1:0]  DMcutSel;

  always #5 Clk = ~Clk;

  dm_arbiter #(.AW(32), .DW(32)) dut (
    .Clk(Clk), .Reset(Reset),
    .m0_req(m0Req), .m1_req(m1Req), .m0_we(m0We), .m1_we(m1We),
    .m0_size(m0Size), .m1_size(m1Size), .m0_ll(m0Ll), .m0_sc(m0Sc),
    .m0_addr(m0Addr), .m1_addr(m1Addr), .m0_wdata(m0Wdata), .m1_wdata(m1Wdata),
    .m0_gnt(m0Gnt), .m1_gnt(m1Gnt), .m0_rvalid(m0Rvalid), .m1_rvalid(m1Rvalid),
    .m0_rdata(m0Rdata), .m1_rdata(m1Rdata), .m0_scok(m0Scok),
    .Ad(Ad), .WrData(WrData), .MemWr(MemWr), .DMcut_sel(DMcutSel), .DM(DM)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // staged master inputs, applied just after each rising edge
  logic        sReq[2], sWe[2];
  logic [1:0]  sSize[2];
  logic [31:0] sAddr[2], sWd[2];
  logic        sLl, sSc;
  logic        gntSeen[2];
  int          gntLogM[$];
  int          gntLogC[$];

  // memory seen by the DUT, and the reference model's own memory
  logic [31:0] envMem[16];
  logic [31:0] refMem[16];
  logic [31:0] nextDm = '0;

  // reference model state: one outstanding transaction described by its grant cycle
  bit          txnActive = 0;
  int          txnG = 0, txnM = 0;
  bit          txnWe, txnSc, txnLl;
  logic [1:0]  txnSize;
  logic [31:0] txnAddr, txnWdata;
  bit          lastGntM1 = 1;
  logic [31:0] latAd = '0, latWd = '0;
  logic [1:0]  latCut = '0;
  bit          resValid = 0;
  logic [29:0] resWord = '0;
  bit          scPassExp = 0;

  function automatic logic [1:0] cutOf(input logic [1:0] s);
    return (s == 2'd1) ? 2'd1 : (s == 2'd2) ? 2'd2 : 2'd0;
  endfunction

  function automatic logic [2:0] storeCode(input logic [1:0] s);
    return (s == 2'd1) ? 3'd2 : (s == 2'd2) ? 3'd4 : 3'd1;
  endfunction

  function automatic logic [31:0] mergeWrite(input logic [31:0] old, input logic [2:0] code,
                                             input logic [1:0] lane, input logic [31:0] wd);
    logic [31:0] r;
    r = old;
    case (code)
      3'd1, 3'd3: r = wd;
      3'd2:       r[int'(lane) * 8 +: 8] = wd[7:0];
      3'd4:       r[int'(lane[1]) * 16 +: 16] = wd[15:0];
      default:    r = old;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] cut, input logic [1:0] lane);
    case (cut)
      2'd1:    return {24'h0, w[int'(lane) * 8 +: 8]};
      2'd2:    return {16'h0, w[int'(lane[1]) * 16 +: 16]};
      default: return w;
    endcase
  endfunction

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s cycle %0d: got 0x%08h expected 0x%08h", name, cyc, act, exp);
    end
  endtask

  task automatic applyStaged();
    m0Req = sReq[0]; m1Req = sReq[1];
    m0We = sWe[0];   m1We = sWe[1];
    m0Size = sSize[0]; m1Size = sSize[1];
    m0Addr = sAddr[0]; m1Addr = sAddr[1];
    m0Wdata = sWd[0];  m1Wdata = sWd[1];
    m0Ll = sLl; m0Sc = sSc;
  endtask

  task automatic resetModel();
    txnActive = 0; lastGntM1 = 1; resValid = 0; scPassExp = 0;
    latAd = '0; latWd = '0; latCut = '0;
  endtask

  // Model: grant in idle cycles, memory access one cycle later, response two cycles later.
  task automatic checkOutput();
    logic        eG0, eG1, eRv0, eRv1, eScok;
    logic [31:0] eRd0, eRd1, eAd, eWd, rd;
    logic [2:0]  eWr;
    logic [1:0]  eCut;
    bit          idleNow;
    int          win, idx;
    idleNow = !txnActive;
    eG0 = 0; eG1 = 0; eRv0 = 0; eRv1 = 0; eScok = 0; eRd0 = '0; eRd1 = '0; eWr = 3'd0;
    eAd = latAd; eWd = latWd; eCut = latCut; win = -1;
    idx = int'(txnAddr[5:2]);
    if (txnActive && cyc == txnG + 1) begin
      if (txnWe) begin
        if (txnSc) begin
`ifdef DM_ATOMIC_EN
          scPassExp = resValid && (resWord == txnAddr[31:2]);
          eWr = scPassExp ? 3'd3 : 3'd0;
`else
          scPassExp = 1;
          eWr = 3'd1;
`endif
        end else begin
          eWr = storeCode(txnSize);
        end
      end
`ifdef DM_ATOMIC_EN
      if (txnLl) begin
        resValid = 1; resWord = txnAddr[31:2];
      end else if (txnWe && resValid && resWord == txnAddr[31:2]) begin
        resValid = 0;
      end
`endif
      if (eWr != 3'd0) refMem[idx] = mergeWrite(refMem[idx], eWr, txnAddr[1:0], txnWdata);
    end
    if (txnActive && cyc == txnG + 2) begin
      rd = txnWe ? 32'h0 : extract(refMem[idx], cutOf(txnSize), txnAddr[1:0]);
      if (txnM == 0) begin eRv0 = 1; eRd0 = rd; eScok = txnSc && scPassExp; end
      else begin eRv1 = 1; eRd1 = rd; end
      txnActive = 0;
    end
    if (idleNow) begin
      if (m0Req && m1Req) win = lastGntM1 ? 0 : 1;
      else if (m0Req)     win = 0;
      else if (m1Req)     win = 1;
      eG0 = (win == 0);
      eG1 = (win == 1);
    end
    checkVal("m0_gnt", m0Gnt, eG0);
    checkVal("m1_gnt", m1Gnt, eG1);
    checkVal("both gnt", m0Gnt & m1Gnt, 0);
    checkVal("MemWr", MemWr, eWr);
    checkVal("Ad", Ad, eAd);
    checkVal("WrData", WrData, eWd);
    checkVal("DMcut_sel", DMcutSel, eCut);
    checkVal("m0_rvalid", m0Rvalid, eRv0);
    checkVal("m1_rvalid", m1Rvalid, eRv1);
    checkVal("m0_rdata", m0Rdata, eRd0);
    checkVal("m1_rdata", m1Rdata, eRd1);
    checkVal("m0_scok", m0Scok, eScok);
    if (win >= 0) begin
      txnActive = 1; txnG = cyc; txnM = win;
      if (win == 0) begin
        txnWe = m0We | m0Sc; txnSc = m0Sc; txnLl = m0Ll & ~m0We & ~m0Sc;
        txnSize = m0Sc ? 2'd0 : m0Size; txnAddr = m0Addr; txnWdata = m0Wdata;
      end else begin
        txnWe = m1We; txnSc = 0; txnLl = 0; txnSize = m1Size; txnAddr = m1Addr; txnWdata = m1Wdata;
      end
      lastGntM1 = (win == 1);
      latAd = txnAddr; latWd = txnWdata; latCut = cutOf(txnSize);
    end
    gntSeen[0] = m0Gnt;
    gntSeen[1] = m1Gnt;
    if (m0Gnt) begin gntLogM.push_back(0); gntLogC.push_back(cyc); end
    if (m1Gnt) begin gntLogM.push_back(1); gntLogC.push_back(cyc); end
  endtask

  // Environment memory: writes on MemWr, returns extended read data the following cycle.
  task automatic envMemory();
    int i;
    i = int'(Ad[5:2]);
    if (MemWr != 3'd0) envMem[i] = mergeWrite(envMem[i], MemWr, Ad[1:0], WrData);
    nextDm = extract(envMem[i], DMcutSel, Ad[1:0]);
  endtask

  task automatic runCycle();
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    DM = nextDm;
    applyStaged();
    @(negedge Clk);
    checkOutput();
    envMemory();
    cyc++;
  endtask

  task automatic checkResetValues();
    checkVal("rst m0_gnt", m0Gnt, 0);
    checkVal("rst m1_gnt", m1Gnt, 0);
    checkVal("rst m0_rvalid", m0Rvalid, 0);
    checkVal("rst m1_rvalid", m1Rvalid, 0);
    checkVal("rst m0_rdata", m0Rdata, 0);
    checkVal("rst m1_rdata", m1Rdata, 0);
    checkVal("rst m0_scok", m0Scok, 0);
    checkVal("rst Ad", Ad, 0);
    checkVal("rst WrData", WrData, 0);
    checkVal("rst MemWr", MemWr, 0);
    checkVal("rst DMcut_sel", DMcutSel, 0);
  endtask

  task automatic applyReset();
    Reset = 1'b1;
    applyStaged();
    #1;
    resetModel();
    checkResetValues();
    runCycle();
  endtask

  task automatic issue(input int m, input bit we, input logic [1:0] size, input bit ll, input bit sc,
                       input logic [31:0] addr, input logic [31:0] wd);
    int k;
    sReq[m] = 1'b1; sWe[m] = we; sSize[m] = size; sAddr[m] = addr; sWd[m] = wd;
    sLl = (m == 0) ? ll : 1'b0;
    sSc = (m == 0) ? sc : 1'b0;
    k = 0;
    do begin
      runCycle();
      k++;
    end while (!gntSeen[m] && k < 20);
    checkVal($sformatf("gnt wait m%0d", m), gntSeen[m], 1);
    sReq[m] = 1'b0; sLl = 1'b0; sSc = 1'b0;
  endtask

  task automatic applyStimulus();
    for (int m = 0; m < 2; m++) begin
      if (gntSeen[m]) sReq[m] = 1'b0;
      if (!sReq[m] && ($urandom_range(0, 2) == 0)) begin
        sReq[m]  = 1'b1;
        sWe[m]   = 1'($urandom_range(0, 1));
        sSize[m] = 2'($urandom_range(0, 3));
        sAddr[m] = 32'($urandom_range(0, 15)) | (($urandom_range(0, 7) == 0) ? 32'h1000 : 32'h0);
        sWd[m]   = $urandom;
        if (m == 0) begin
          sLl = ($urandom_range(0, 3) == 0);
          sSc = ($urandom_range(0, 5) == 0);
        end
      end
    end
  endtask

  initial begin
    logic [31:0] v;
    for (int i = 0; i < 16; i++) begin
      v = $urandom;
      envMem[i] = v;
      refMem[i] = v;
    end
    for (int m = 0; m < 2; m++) begin
      sReq[m] = 0; sWe[m] = 0; sSize[m] = 0; sAddr[m] = 0; sWd[m] = 0; gntSeen[m] = 0;
    end
    sLl = 0; sSc = 0;
    applyReset();

    // word store then byte load of the same address
    issue(0, 1, 2'd0, 0, 0, 32'h10, 32'hDEADBEEF);
    runCycle();
    checkVal("st MemWr", MemWr, 3'd1);
    checkVal("st Ad", Ad, 32'h10);
    checkVal("st WrData", WrData, 32'hDEADBEEF);
    runCycle();
    checkVal("st m0_rvalid", m0Rvalid, 1);
    checkVal("st m0_rdata", m0Rdata, 0);
    issue(0, 0, 2'd1, 0, 0, 32'h10, 32'h0);
    runCycle();
    checkVal("ldb MemWr", MemWr, 0);
    checkVal("ldb DMcut_sel", DMcutSel, 2'd1);
    runCycle();
    checkVal("ldb m0_rvalid", m0Rvalid, 1);
    checkVal("ldb m0_rdata", m0Rdata, 32'h000000EF);

    // m1 halfword store
    issue(1, 1, 2'd2, 0, 0, 32'h24, 32'h00001234);
    runCycle();
    checkVal("sth MemWr", MemWr, 3'd4);
    runCycle();
    checkVal("sth MemWr after", MemWr, 0);
    checkVal("sth m1_rvalid", m1Rvalid, 1);
    checkVal("sth m1_rdata", m1Rdata, 0);

`ifdef DM_ATOMIC_EN
    issue(0, 0, 2'd0, 1, 0, 32'h20, 32'h0);
    runCycle(); runCycle();
    issue(0, 0, 2'd0, 0, 1, 32'h20, 32'hCAFE0001);
    runCycle();
    checkVal("sc ok MemWr", MemWr, 3'd3);
    runCycle();
    checkVal("sc ok m0_scok", m0Scok, 1);
    issue(0, 0, 2'd0, 1, 0, 32'h20, 32'h0);
    runCycle(); runCycle();
    issue(1, 1, 2'd2, 0, 0, 32'h22, 32'h00005555);
    runCycle(); runCycle();
    issue(0, 0, 2'd0, 0, 1, 32'h20, 32'hCAFE0002);
    runCycle();
    checkVal("sc fail MemWr", MemWr, 0);
    runCycle();
    checkVal("sc fail m0_rvalid", m0Rvalid, 1);
    checkVal("sc fail m0_scok", m0Scok, 0);
`else
    issue(0, 0, 2'd0, 0, 1, 32'h30, 32'hCAFE0003);
    runCycle();
    checkVal("sc plain MemWr", MemWr, 3'd1);
    runCycle();
    checkVal("sc plain m0_scok", m0Scok, 1);
`endif

    // reset during the access cycle of an m0 load
    issue(0, 0, 2'd0, 0, 0, 32'h10, 32'h0);
    runCycle();
    applyReset();
    runCycle();
    checkVal("post-reset m0_rvalid", m0Rvalid, 0);
    issue(0, 0, 2'd1, 0, 0, 32'h10, 32'h0);
    runCycle(); runCycle();
    checkVal("post-reset m0_rdata", m0Rdata, 32'h000000EF);

    // both masters requesting continuously from reset
    sReq[0] = 1; sWe[0] = 0; sSize[0] = 2'd0; sAddr[0] = 32'h10;
    sReq[1] = 1; sWe[1] = 0; sSize[1] = 2'd0; sAddr[1] = 32'h24;
    gntLogM.delete(); gntLogC.delete();
    applyReset();
    repeat (12) runCycle();
    checkVal("alt grant count", 32'(gntLogM.size() >= 4), 1);
    if (gntLogM.size() >= 4) begin
      for (int i = 0; i < 4; i++) begin
        checkVal($sformatf("alt winner %0d", i), gntLogM[i], i % 2);
        if (i > 0) checkVal($sformatf("alt spacing %0d", i), gntLogC[i] - gntLogC[i-1], 3);
      end
    end
    sReq[0] = 0; sReq[1] = 0;

    repeat (800) begin
      applyStimulus();
      runCycle();
    end
    sReq[0] = 0; sReq[1] = 0; sLl = 0; sSc = 0;
    repeat (4) runCycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dm_arbiter.md
# dm_arbiter

Sequencer and two-master arbiter in front of the data memory. It accepts load/store requests from the CPU load/store port (m0) and a secondary DMA/debug port (m1), and shares the single data memory between them with round-robin arbitration. It translates each request into the memory's write-mode code and read-extension select, and returns read data or write completion with a one-cycle valid pulse. It also owns the load-linked/store-conditional reservation behind the memory's atomic-write mode.

## Interface
- AW, 32, address width of both masters and memory
- DW, 32, data width
- Clk  in  1  clock
- Reset  in  1  asynchronous, active-high reset
- m0_req, m1_req  in  1  request; held with fields stable until grant
- m0_we, m1_we  in  1  1 = store, 0 = load
- m0_size, m1_size  in  2  0 = word, 1 = byte, 2 = halfword; 3 treated as word
- m0_ll  in  1  load-linked (m0 only; meaningful when m0_we = 0)
- m0_sc  in  1  store-conditional (m0 only; forces store, word size)
- m0_addr, m1_addr  in  AW  byte address
- m0_wdata, m1_wdata  in  DW  store data
- m0_gnt, m1_gnt  out  1  request accepted this cycle (combinational)
- m0_rvalid, m1_rvalid  out  1  one-cycle completion pulse for loads and stores
- m0_rdata, m1_rdata  out  DW  load data, valid with rvalid; otherwise 0
- m0_scok  out  1  valid with m0_rvalid on an SC: 1 = store performed
- Ad  out  AW  memory address
- WrData  out  DW  memory write data
- MemWr  out  3  0 = read, 1 = word write, 2 = byte write, 3 = atomic word write, 4 = halfword write
- DMcut_sel  out  2  0 = word, 1 = byte zero-extend, 2 = halfword zero-extend
- DM  in  DW  memory read data; valid the cycle after a read is driven

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If any req, grant exactly one master and latch its fields at the clock edge; next state ACCESS.
  - If both request, grant the master not granted last.
  - The last-grant pointer resets to m1, so m0 wins the first tie.
- ACCESS:
  - Drive Ad, WrData and DMcut_sel from the latched request.
  - MemWr = size-mapped write code for stores (word→1, byte→2, half→4), 0 for loads.
  - Next state RESP.
- RESP:
  - Pulse rvalid of the owning master.
  - For loads, rdata = DM.
  - Update the last-grant pointer; next state IDLE.
- Outside ACCESS: MemWr = 0, Ad/WrData hold their latched values, and DMcut_sel holds its latched value so DM stays stable through RESP.
- If m0_ll and m0_sc are both set, the request is treated as SC.

## Timing
- Grant cycle T, memory access T+1, rvalid at T+2. Throughput: one transaction per 3 cycles.
- gnt is only asserted in IDLE. A requester may drop req after gnt; a new req is accepted no earlier than T+3.
- Reset values: state IDLE, all gnt/rvalid/scok 0, rdata 0, Ad 0, WrData 0, MemWr 0, DMcut_sel 0, reservation invalid, pointer = m1.
- Reset asserted mid-transaction:
  - The in-flight request is dropped with no rvalid.
  - A store in ACCESS may or may not have landed.
  - The requester must re-issue.

## Configuration
- Macro DM_ATOMIC_EN.
- Defined: reservation register (valid bit plus address[AW-1:2]) is present.
  - m0_ll load: sets the reservation to the word address.
  - m0_sc with reservation valid and word address match: MemWr = 3, scok = 1, reservation cleared.
  - m0_sc otherwise: MemWr = 0 during ACCESS (no write), scok = 0.
  - Any granted store from either master to the reserved word clears the reservation at its ACCESS edge.
  - A second ll replaces the reservation.
- Undefined: no reservation logic.
  - ll acts as a plain load.
  - sc acts as a plain word store (MemWr = 1) with scok = 1.

## Test plan
- m0 word store 0xDEADBEEF to 0x10, then m0 byte load from 0x10 → MemWr = 1 at T+1; load m0_rdata = 0x000000EF, DMcut_sel = 1, rvalid at T+2.
- m0_req and m1_req held continuously from reset → grants alternate m0, m1, m0, m1, each 3 cycles apart; no cycle with both gnt high.
- m1 halfword store 0x1234 → MemWr = 4 for exactly one cycle; m1_rvalid pulses at T+2 with m1_rdata = 0.
- With DM_ATOMIC_EN:
  - m0 ll 0x20, then m0 sc 0x20 → MemWr = 3, scok = 1.
  - Repeat with an m1 store to 0x22 in between → sc gives MemWr = 0, scok = 0.
- Reset asserted during ACCESS of an m0 load → no m0_rvalid, all outputs at reset values, next m0 request granted normally.
- Without DM_ATOMIC_EN: m0 sc to an unreserved address → MemWr = 1, scok = 1.
